// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART receiver: parallel byte plus its frame-end
// strobes. The receiver drives it through the master modport and the
// system-side consumer reads it through the slave modport.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output P_DATA,
    output data_valid,
    output par_err,
    output stp_err
  );

  modport slave (
    input P_DATA,
    input data_valid,
    input par_err,
    input stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver. It oversamples RX_IN at Prescale clocks per bit and
// majority-votes three mid-bit samples. It checks the start bit, the
// optional parity bit and the stop bit. At the end of each frame it raises
// one-cycle data_valid / par_err / stp_err strobes. Frame configuration is
// latched when a frame starts, so pin changes during a frame have no effect.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  uart_rx_if.master             rx_bus
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Majority of three samples, so that a single-sample glitch is rejected.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity of a data word (XOR of all bits).
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [PRESCALE_W-1:0]   edge_cnt_r;
  logic [BIT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [PRESCALE_W-1:0]   presc_r;
  logic                    par_en_r;
  logic                    par_typ_r;
  logic [1:0]              samp_r;
  logic                    par_bad_r;
  logic                    stp_bad_r;

  logic [PRESCALE_W-1:0]   half_s;
  logic                    edge_last_s;
  logic                    mid_s;
  logic                    vote_s;
  logic                    frame_end_s;
  logic                    glitch_s;
  logic                    enter_start_s;

  // The third sample is the live line, so the vote is available at P/2+1.
  assign half_s        = {1'b0, presc_r[PRESCALE_W-1:1]};
  assign edge_last_s   = (edge_cnt_r == (presc_r - ONE));
  assign mid_s         = (edge_cnt_r == (half_s + ONE));
  assign vote_s        = majority3(samp_r[0], samp_r[1], RX_IN);
  assign frame_end_s   = (state_r == STOP) && edge_last_s;
  assign glitch_s      = (state_r == START) && mid_s && vote_s;
  // A low line at frame end starts the next frame with no lost clock.
  assign enter_start_s = !RX_IN && ((state_r == IDLE) || frame_end_s);

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: advance on bit boundaries, abort on a false start bit.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!RX_IN) state_nxt_s = START;
        else        state_nxt_s = IDLE;
      end
      START: begin
        if (glitch_s)         state_nxt_s = IDLE;
        else if (edge_last_s) state_nxt_s = DATA;
        else                  state_nxt_s = START;
      end
      DATA: begin
        if (edge_last_s && (bit_cnt_r == BIT_LAST)) begin
          if (par_en_r) state_nxt_s = PARITY;
          else          state_nxt_s = STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      PARITY: begin
        if (edge_last_s) state_nxt_s = STOP;
        else             state_nxt_s = PARITY;
      end
      STOP: begin
        if (edge_last_s) begin
          if (RX_IN) state_nxt_s = IDLE;
          else       state_nxt_s = START;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: counters, config latch, sampling, shift register, error flags, strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_r        <= '0;
      bit_cnt_r         <= '0;
      shift_r           <= '0;
      presc_r           <= PRESCALE_W'(8);
      par_en_r          <= 1'b0;
      par_typ_r         <= 1'b0;
      samp_r            <= 2'b11;
      par_bad_r         <= 1'b0;
      stp_bad_r         <= 1'b0;
      rx_bus.P_DATA     <= '0;
      rx_bus.data_valid <= 1'b0;
      rx_bus.par_err    <= 1'b0;
      rx_bus.stp_err    <= 1'b0;
    end else begin
      rx_bus.data_valid <= 1'b0;
      rx_bus.par_err    <= 1'b0;
      rx_bus.stp_err    <= 1'b0;

      // Edge/bit counting; every new frame starts from edge 0, bit 0.
      if (enter_start_s) begin
        presc_r    <= Prescale;
        par_en_r   <= PAR_EN;
        par_typ_r  <= PAR_TYP;
        par_bad_r  <= 1'b0;
        stp_bad_r  <= 1'b0;
        edge_cnt_r <= '0;
        bit_cnt_r  <= '0;
      end else if ((state_r == IDLE) || glitch_s || edge_last_s) begin
        edge_cnt_r <= '0;
        if ((state_r == DATA) && edge_last_s) bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        else                                  bit_cnt_r <= bit_cnt_r;
      end else begin
        edge_cnt_r <= edge_cnt_r + ONE;
      end

      // First two mid-bit samples; the third is taken live by the vote.
      if (state_r != IDLE) begin
        if (edge_cnt_r == (half_s - ONE)) samp_r[0] <= RX_IN;
        else                              samp_r[0] <= samp_r[0];
        if (edge_cnt_r == half_s)         samp_r[1] <= RX_IN;
        else                              samp_r[1] <= samp_r[1];
      end else begin
        samp_r <= samp_r;
      end

      // Act on the voted bit value once per bit.
      if (mid_s) begin
        case (state_r)
          DATA:    shift_r   <= {vote_s, shift_r[DATA_WIDTH-1:1]};
          PARITY:  par_bad_r <= vote_s != (even_parity(shift_r) ^ par_typ_r);
          STOP:    stp_bad_r <= !vote_s;
          default: shift_r   <= shift_r;
        endcase
      end else begin
        shift_r <= shift_r;
      end

      // Frame end: publish the byte only when the frame is clean.
      if (frame_end_s) begin
        rx_bus.data_valid <= !par_bad_r && !stp_bad_r;
        rx_bus.par_err    <= par_bad_r;
        rx_bus.stp_err    <= stp_bad_r;
        if (!par_bad_r && !stp_bad_r) rx_bus.P_DATA <= shift_r;
        else                          rx_bus.P_DATA <= rx_bus.P_DATA;
      end else begin
        rx_bus.P_DATA <= rx_bus.P_DATA;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. It serialises frames onto RX_IN and
// predicts each frame's outcome from the frame's bits: strobe kind, strobe
// cycle and the byte on P_DATA. A negedge monitor compares every strobe the
// DUT raises against the queue of predicted outcomes.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;

  always #5 CLK = ~CLK;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX_IN    (RX_IN),
    .Prescale (Prescale),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .rx_bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
  } exp_t;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  int         prev_dv_cyc = 0;
  int         dv_gap = 0;

  // Count one comparison and report it if the observed value differs.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Posedge counter used to timestamp strobes.
  always @(posedge CLK) cyc <= cyc + 1;

  // Match every strobe the DUT raises against the next predicted frame outcome.
  always @(negedge CLK) begin
    if (RST && (bus.data_valid || bus.par_err || bus.stp_err)) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("strobe_cycle", cyc, mon_e.cyc);
        check_eq("data_valid", {31'd0, bus.data_valid}, {31'd0, mon_e.dv});
        check_eq("par_err", {31'd0, bus.par_err}, {31'd0, mon_e.pe});
        check_eq("stp_err", {31'd0, bus.stp_err}, {31'd0, mon_e.se});
        check_eq("p_data", {24'd0, bus.P_DATA}, {24'd0, mon_e.data});
        if (bus.data_valid) begin
          dv_gap      = cyc - prev_dv_cyc;
          prev_dv_cyc = cyc;
        end
      end
    end
  end

  // Hold the line idle for n clocks; leaves time at #1 after a posedge.
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Serialise one frame (called at #1 after a posedge) and queue its predicted outcome.
  // The start edge driven now is seen at the next posedge; the frame then lasts
  // nbits*p clocks and the registered strobe shows one clock later.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic bad_par, input logic stop_v);
    logic bits[$];
    exp_t e;
    logic good;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt ^ bad_par);
    bits.push_back(stop_v);
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    good   = !(pe && bad_par) && stop_v;
    e.cyc  = cyc + bits.size() * p + 1;
    e.dv   = good;
    e.pe   = pe && bad_par;
    e.se   = !stop_v;
    e.data = good ? d : last_good;
    if (good) last_good = d;
    exp_q.push_back(e);
    for (int i = 0; i < bits.size(); i++) begin
      RX_IN = bits[i];
      if (i == 1) begin
        // Pin changes mid-frame must not disturb the frame in progress.
        Prescale = 6'(8 << $urandom_range(0, 2));
        PAR_EN   = 1'($urandom_range(0, 1));
        PAR_TYP  = 1'($urandom_range(0, 1));
      end
      repeat (p) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [7:0] d;
    int         p;
    logic       pe, pt, bp, sv;

    // Reset state.
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_p_data", {24'd0, bus.P_DATA}, 32'd0);
    check_eq("rst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check_eq("rst_par_err", {31'd0, bus.par_err}, 32'd0);
    check_eq("rst_stp_err", {31'd0, bus.stp_err}, 32'd0);
    RST = 1'b1;
    idle(5);

    // Good even-parity frame, then bad parity (P_DATA must keep 0xA5).
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10);
    check_eq("after_a5", {24'd0, bus.P_DATA}, 32'h0000_00A5);
    send_frame(8'h11, 8, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(10);
    check_eq("hold_after_par_err", {24'd0, bus.P_DATA}, 32'h0000_00A5);

    // Odd parity with correct parity bit but stop error; then both errors at once.
    send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    send_frame(8'h77, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Start glitch: two low clocks must not produce any strobe.
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    idle(40);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    check_eq("after_glitch_5a", {24'd0, bus.P_DATA}, 32'h0000_005A);

    // Back-to-back frames with no idle gap: data_valid period equals frame length.
    send_frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    check_eq("b2b_gap", dv_gap, 32'd320);

    // Reset in the middle of data bit 3.
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    d = 8'hC6;
    RX_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      RX_IN = d[i];
      repeat (8) @(posedge CLK);
      #1;
    end
    RX_IN = d[3];
    repeat (4) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check_eq("midrst_p_data", {24'd0, bus.P_DATA}, 32'd0);
    check_eq("midrst_data_valid", {31'd0, bus.data_valid}, 32'd0);
    check_eq("midrst_par_err", {31'd0, bus.par_err}, 32'd0);
    check_eq("midrst_stp_err", {31'd0, bus.stp_err}, 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    RST = 1'b1;
    last_good = 8'h00;
    idle(5);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    check_eq("after_rst_81", {24'd0, bus.P_DATA}, 32'h0000_0081);

    // Randomised frames: prescale, parity mode, errors and gaps all vary.
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom);
      p  = 8 << $urandom_range(0, 2);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      bp = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      send_frame(d, p, pe, pt, bp, sv);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20));
    end
    idle(60);
    check_eq("pending_strobes", exp_q.size(), 32'd0);
    check_eq("final_p_data", {24'd0, bus.P_DATA}, {24'd0, last_good});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
